// File: rtl/bf_iteration_controller_if.sv
// Handshake bundle between the Bellman-Ford iteration controller and its environment.
// The master side is the controller; the slave side is the AGU/PE array and host.
interface bf_iteration_controller_if;
  logic       start;
  logic       relax_changed;
  logic       iteration_done;
  logic       read_enable_cu;
  logic       pre_rollover_phase_counter;
  logic       rollover_phase_counter;
  logic       busy;
  logic       done;
  logic       converged;
  logic [7:0] iteration_count;
  logic       sync_error;

  modport master (
    input  start,
    input  relax_changed,
    input  iteration_done,
    output read_enable_cu,
    output pre_rollover_phase_counter,
    output rollover_phase_counter,
    output busy,
    output done,
    output converged,
    output iteration_count,
    output sync_error
  );

  modport slave (
    output start,
    output relax_changed,
    output iteration_done,
    input  read_enable_cu,
    input  pre_rollover_phase_counter,
    input  rollover_phase_counter,
    input  busy,
    input  done,
    input  converged,
    input  iteration_count,
    input  sync_error
  );
endinterface

// File: rtl/bf_iteration_controller.sv
// Sequencing controller for the 16x16 Bellman-Ford array: drives the column phase
// counter and AGU strobes, counts relaxation sweeps, stops on convergence or the
// iteration cap, and cross-checks its column count against the AGU.
module bf_iteration_controller #(
  parameter int unsigned NUMBER_OF_COLUMNS = 16,
  parameter int unsigned PHASE_LENGTH      = 4,
  parameter int unsigned MAX_ITERATIONS    = 15,
  parameter int unsigned PIPE_DELAY        = 2
) (
  input logic                        clk,
  input logic                        rst_global,
  bf_iteration_controller_if.master  bus
);

  localparam int unsigned PhW       = $clog2(PHASE_LENGTH);
  localparam int unsigned ColW      = (NUMBER_OF_COLUMNS > 1) ? $clog2(NUMBER_OF_COLUMNS) : 1;
  localparam int unsigned DrW       = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
  localparam int unsigned DrLastInt = (PIPE_DELAY == 0) ? 0 : PIPE_DELAY - 1;

  localparam logic [PhW-1:0]  PhLast  = PhW'(PHASE_LENGTH - 1);
  localparam logic [PhW-1:0]  PhPre   = PhW'(PHASE_LENGTH - 2);
  localparam logic [ColW-1:0] ColLast = ColW'(NUMBER_OF_COLUMNS - 1);
  localparam logic [DrW-1:0]  DrLast  = DrW'(DrLastInt);
  localparam logic [8:0]      MaxIter = 9'(MAX_ITERATIONS);

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [ColW-1:0] col_q, col_d;
  logic [DrW-1:0]  drain_q, drain_d;
  logic            flag_q, flag_d;
  logic [7:0]      iter_q, iter_d;
  logic            conv_q, conv_d;
  logic            sync_q, sync_d;
  logic            re_q, busy_q, done_q;

  logic in_run, rollover, pre_rollover, sweep_end, eff_changed, cap_hit, stop_run;

  assign in_run       = (state_q == StRun);
  assign rollover     = in_run && (ph_q == PhLast);
  assign pre_rollover = in_run && (ph_q == PhPre);
  assign sweep_end    = rollover && (col_q == ColLast);
  // A change seen in the final rollover cycle still belongs to the current sweep.
  assign eff_changed  = flag_q | bus.relax_changed;
  assign cap_hit      = ({1'b0, iter_q} + 9'd1) == MaxIter;
  assign stop_run     = !eff_changed || cap_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_global) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StPrime;
      StPrime: state_d = StRun;
      StRun:   if (sweep_end && stop_run) state_d = (PIPE_DELAY == 0) ? StDone : StDrain;
      StDrain: if (drain_q == DrLast) state_d = StDone;
      StDone:  if (bus.start) state_d = StPrime;
      default: state_d = StIdle;
    endcase
  end

  // Counter, flag and status next-state; everything is cleared on entry to PRIME.
  always_comb begin
    ph_d    = ph_q;
    col_d   = col_q;
    flag_d  = flag_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    sync_d  = sync_q;
    drain_d = drain_q;
    if ((state_d == StPrime) && (state_q != StPrime)) begin
      ph_d    = '0;
      col_d   = '0;
      flag_d  = 1'b0;
      iter_d  = '0;
      conv_d  = 1'b0;
      sync_d  = 1'b0;
      drain_d = '0;
    end else if (in_run) begin
      drain_d = '0;
      flag_d  = eff_changed;
      if (rollover) begin
        ph_d = '0;
        if (sweep_end) begin
          col_d  = '0;
          iter_d = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
          if (!bus.iteration_done) sync_d = 1'b1;
          if (stop_run) begin
            conv_d = !eff_changed;
          end else begin
            flag_d = 1'b0;
          end
        end else begin
          col_d = col_q + 1'b1;
          if (bus.iteration_done) sync_d = 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end else if (state_q == StDrain) begin
      drain_d = drain_q + 1'b1;
    end
  end

  // Datapath and registered-output flops.
  always_ff @(posedge clk) begin
    if (!rst_global) begin
      ph_q    <= '0;
      col_q   <= '0;
      drain_q <= '0;
      flag_q  <= 1'b0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      sync_q  <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      flag_q  <= flag_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      sync_q  <= sync_d;
      re_q    <= (state_d == StPrime);
      busy_q  <= (state_d == StPrime) || (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_d == StDone);
    end
  end

  // Outputs: phase strobes are combinational from ph, the rest come from flops.
  always_comb begin
    bus.read_enable_cu             = re_q;
    bus.pre_rollover_phase_counter = pre_rollover;
    bus.rollover_phase_counter     = rollover;
    bus.busy                       = busy_q;
    bus.done                       = done_q;
    bus.converged                  = conv_q;
    bus.iteration_count            = iter_q;
    bus.sync_error                 = sync_q;
  end

endmodule

// File: doc/bf_iteration_controller.md
# bf_iteration_controller

Sequencing controller for the 16x16 Bellman-Ford array, sitting directly upstream of the address generator (AGU). It runs the column phase counter and issues the AGU's `read_enable_cu`, `rollover_phase_counter` and `pre_rollover_phase_counter` strobes. It counts relaxation iterations and stops on convergence (no distance changed in a full sweep) or after `MAX_ITERATIONS`. It cross-checks its column count against the AGU's `iteration_done`, reports `done`/`converged`, and flags a sticky sync error on mismatch.

## Interface
- `NUMBER_OF_COLUMNS`, 16: columns per sweep; must match the AGU's `number_of_columns`.
- `PHASE_LENGTH`, 4: clock cycles per column phase; must be ≥ 2.
- `MAX_ITERATIONS`, 15: iteration cap (N-1 for 16 nodes); range 1..255.
- `PIPE_DELAY`, 2: drain cycles after the last rollover, covering PE-to-DRAM write latency.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_global`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; starts a run; sampled only in IDLE or DONE.
- `relax_changed`  in  1  OR of PE "distance updated" flags; sampled every RUN cycle.
- `iteration_done`  in  1  from the AGU; high when its write address = `NUMBER_OF_COLUMNS`-1.
- `read_enable_cu`  out  1  one-cycle prime pulse to the AGU read counter.
- `pre_rollover_phase_counter`  out  1  high in the phase cycle `PHASE_LENGTH`-2.
- `rollover_phase_counter`  out  1  high in the phase cycle `PHASE_LENGTH`-1.
- `busy`  out  1  high in PRIME, RUN and DRAIN.
- `done`  out  1  high in DONE.
- `converged`  out  1  valid while `done`; 1 means the last sweep had no change.
- `iteration_count`  out  8  completed sweeps.
- `sync_error`  out  1  sticky; column count and `iteration_done` disagree.

## Operation
- FSM states: IDLE, PRIME, RUN, DRAIN, DONE.
- **IDLE:** all outputs 0. `start`=1 → PRIME.
- **PRIME:** exactly one cycle, with `read_enable_cu`=1 (pre-advances the AGU read address). Clears `iteration_count`, `sync_error`, `converged`, the change flag, the phase counter and the column counter. → RUN.
- **RUN:**
  - The phase counter `ph` counts 0..`PHASE_LENGTH`-1 and wraps.
  - `pre_rollover_phase_counter` = (`ph`==`PHASE_LENGTH`-2); `rollover_phase_counter` = (`ph`==`PHASE_LENGTH`-1). Both are combinational from `ph` and gated by RUN.
  - Each rollover increments the column counter `col` (0..`NUMBER_OF_COLUMNS`-1, wrapping).
  - A sticky change flag is set by any `relax_changed`=1 in RUN. This includes the cycle of the final rollover, which counts toward the current sweep.
- **End of sweep** = a rollover with `col`==`NUMBER_OF_COLUMNS`-1:
  - `iteration_count` increments.
  - If `iteration_done`=0 in that cycle, `sync_error` is set.
  - If `iteration_done`=1 in any other RUN rollover cycle, `sync_error` is also set.
  - If the effective flag (flag OR current `relax_changed`) is 0: `converged`<=1, → DRAIN.
  - Else if `iteration_count`+1 == `MAX_ITERATIONS`: `converged`<=0, → DRAIN.
  - Else the flag clears and RUN continues; `ph` wraps to 0 with no bubble.
- **DRAIN:** counts `PIPE_DELAY` cycles with all strobes 0, then → DONE. `PIPE_DELAY`=0 goes straight to DONE.
- **DONE:** `done`=1. `converged`, `iteration_count` and `sync_error` are held. `start` → PRIME (a new run).
- `start` is ignored in PRIME, RUN and DRAIN.
- `relax_changed` is ignored outside RUN.
- `iteration_count` saturates at 255 (unreachable under the stated parameter range).

## Timing
- Reset: `rst_global`=0 at an edge → state IDLE. After that edge, all outputs, counters and flags are 0. Reset mid-run aborts with no further strobes.
- Cycle numbering: `start` sampled at edge 0. PRIME occupies cycle 1; RUN begins at cycle 2 with `ph`=0.
- Default parameters:
  - `pre_rollover_phase_counter` is first high in cycle 4; `rollover_phase_counter` is first high in cycle 5.
  - One sweep = `NUMBER_OF_COLUMNS`×`PHASE_LENGTH` = 64 cycles.
  - A one-sweep run: RUN in cycles 2..65, DRAIN in 66..67, `done`=1 from cycle 68.
- Each strobe is one cycle wide per phase. `pre_rollover_phase_counter` and `rollover_phase_counter` are never high together.
- All outputs are registered except the two phase strobes.

## Test plan
- **Reset:** hold `rst_global`=0 for 3 cycles mid-RUN → next cycle all outputs 0, state IDLE; a subsequent `start` is accepted.
- **Immediate convergence:** `start`, `relax_changed`=0, AGU model attached → `read_enable_cu` high in cycle 1 only; 16 rollovers; `done`=1 at cycle 68; `converged`=1; `iteration_count`=1; `sync_error`=0.
- **Iteration cap:** `relax_changed` pulsed once per sweep → 15 sweeps; `done` at cycle 2+15×64+2 = 964; `converged`=0; `iteration_count`=15.
- **Late change:** `relax_changed`=1 only in the final-rollover cycle of sweep 1 → a second sweep runs; `done` at cycle 132; `converged`=1; `iteration_count`=2.
- **Sync check:** AGU model write address offset by +1 → `sync_error`=1 at the first sweep end and held through DONE.
- **Start handling:** `start` pulsed during RUN → ignored, no restart. `start` pulsed in DONE → PRIME next cycle; counters cleared.
